// File: rtl/fifo_ref_model_if.sv
// Write/read request bundle and registered/flag responses of the FIFO golden model.
// The master drives requests; the slave (the model) returns data and status.
// No internal flow control; requests are sampled every clock.
interface fifo_ref_model_if #(
    parameter int FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out_ref;
    logic                  wr_ack_ref;
    logic                  overflow_ref;
    logic                  underflow_ref;
    logic                  full_ref;
    logic                  almostfull_ref;
    logic                  empty_ref;
    logic                  almostempty_ref;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out_ref, wr_ack_ref, overflow_ref, underflow_ref,
               full_ref, almostfull_ref, empty_ref, almostempty_ref
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out_ref, wr_ack_ref, overflow_ref, underflow_ref,
               full_ref, almostfull_ref, empty_ref, almostempty_ref
    );
endinterface

// File: rtl/fifo_ref_model.sv
// Cycle-accurate golden synchronous FIFO used as the scoreboard reference.
// Latency: write at edge N readable at edge N+1; status outputs registered one cycle, flags combinational.
// Backpressure: writes when full raise overflow, reads when empty raise underflow; nothing stalls.
module fifo_ref_model #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_ref_model_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance is judged on the pre-edge count, so a read on full frees no room
    // for a same-cycle write, and a write on empty supplies nothing to a same-cycle read.
    assign wr_acc = bus.wr_en && (count < FULL_CNT);
    assign rd_acc = bus.rd_en && (count != '0);

    // Storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_acc;
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;

            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end

            if (rd_acc) begin
                data_out_q <= mem[rd_ptr];
                rd_ptr     <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.data_out_ref    = data_out_q;
    assign bus.wr_ack_ref      = wr_ack_q;
    assign bus.overflow_ref    = overflow_q;
    assign bus.underflow_ref   = underflow_q;
    assign bus.full_ref        = (count == FULL_CNT);
    assign bus.almostfull_ref  = (count == AFULL_CNT);
    assign bus.empty_ref       = (count == '0);
    assign bus.almostempty_ref = (count == AEMPTY_CNT);
endmodule

// File: tb/tb_fifo_ref_model.sv
// Self-checking bench for fifo_ref_model against a queue-based behavioural FIFO.
module tb_fifo_ref_model;
    localparam int W = 16;
    localparam int D = 8;

    logic clk;
    logic rst_n;

    fifo_ref_model_if #(.FIFO_WIDTH(W)) bus ();

    fifo_ref_model #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: a queue of stored words plus last-cycle status.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_ack;
    logic         m_ovf;
    logic         m_udf;

    function automatic void model_reset();
        q.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic r, input logic [W-1:0] d);
        bit wr_ok;
        bit rd_ok;
        wr_ok = w && (q.size() < D);
        rd_ok = r && (q.size() > 0);
        m_ack = wr_ok;
        m_ovf = w && !wr_ok;
        m_udf = r && !rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
    endfunction

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic apply(input logic w, input logic r, input logic [W-1:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        if (rst_n) model_step(w, r, d);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    function automatic logic [3:0] exp_flags();
        int n;
        n = q.size();
        return {n == D, n == D - 1, n == 0, n == 1};
    endfunction

    function automatic logic [3:0] got_flags();
        return {bus.full_ref, bus.almostfull_ref, bus.empty_ref, bus.almostempty_ref};
    endfunction

    task automatic test_reset();
        logic [W+4:0] got;
        model_reset();
        #3;
        got = {bus.data_out_ref, bus.wr_ack_ref, bus.overflow_ref, bus.underflow_ref,
               bus.full_ref, bus.empty_ref};
        n_cmp++;
        if (got !== {16'h0000, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", got, {16'h0000, 5'b00001});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, '0);
            got = {bus.data_out_ref, bus.wr_ack_ref, bus.overflow_ref, bus.underflow_ref,
                   bus.full_ref, bus.empty_ref};
            n_cmp++;
            if (got !== {16'h0000, 5'b00001}) begin
                n_fail++;
                $display("FAIL reset_idle%0d: got %h expected %h", i, got, {16'h0000, 5'b00001});
            end
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] d;
        for (int i = 1; i <= 9; i++) begin
            d = (i <= 8) ? W'(i) : 16'hFFFF;
            apply(1'b1, 1'b0, d);
            n_cmp++;
            if ({bus.wr_ack_ref, bus.overflow_ref, got_flags()} !== {m_ack, m_ovf, exp_flags()}) begin
                n_fail++;
                $display("FAIL fill_w%0d: got ack/ovf/flags %b expected %b", i,
                         {bus.wr_ack_ref, bus.overflow_ref, got_flags()}, {m_ack, m_ovf, exp_flags()});
            end
        end
        n_cmp++;
        if ({bus.overflow_ref, bus.wr_ack_ref, bus.full_ref} !== 3'b101) begin
            n_fail++;
            $display("FAIL fill_overflow: got %b expected 101",
                     {bus.overflow_ref, bus.wr_ack_ref, bus.full_ref});
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 9; i++) begin
            apply(1'b0, 1'b1, '0);
            n_cmp++;
            if ({bus.data_out_ref, bus.underflow_ref, got_flags()} !== {m_dout, m_udf, exp_flags()}) begin
                n_fail++;
                $display("FAIL drain_r%0d: got dout %h udf/flags %b expected %h %b", i,
                         bus.data_out_ref, {bus.underflow_ref, got_flags()}, m_dout, {m_udf, exp_flags()});
            end
        end
        n_cmp++;
        if ({bus.data_out_ref, bus.underflow_ref, bus.empty_ref} !== {16'h0008, 2'b11}) begin
            n_fail++;
            $display("FAIL drain_hold: got %h expected %h",
                     {bus.data_out_ref, bus.underflow_ref, bus.empty_ref}, {16'h0008, 2'b11});
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b1, 1'b1, 16'h00AA);
        n_cmp++;
        if ({bus.underflow_ref, bus.wr_ack_ref, got_flags()} !== {m_udf, m_ack, exp_flags()}) begin
            n_fail++;
            $display("FAIL simul_empty: got %b expected %b",
                     {bus.underflow_ref, bus.wr_ack_ref, got_flags()}, {m_udf, m_ack, exp_flags()});
        end
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, W'($urandom));
        apply(1'b1, 1'b1, W'($urandom));
        n_cmp++;
        if ({bus.data_out_ref, got_flags()} !== {m_dout, exp_flags()} || q.size() != 4) begin
            n_fail++;
            $display("FAIL simul_mid: got %h %b expected %h %b", bus.data_out_ref, got_flags(),
                     m_dout, exp_flags());
        end
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, W'($urandom));
        apply(1'b1, 1'b1, W'($urandom));
        n_cmp++;
        if ({bus.data_out_ref, bus.overflow_ref, bus.wr_ack_ref, got_flags()} !==
            {m_dout, m_ovf, m_ack, exp_flags()}) begin
            n_fail++;
            $display("FAIL simul_full: got %h %b expected %h %b", bus.data_out_ref,
                     {bus.overflow_ref, bus.wr_ack_ref, got_flags()}, m_dout, {m_ovf, m_ack, exp_flags()});
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        while (q.size() > 0) apply(1'b0, 1'b1, '0);
        d = 16'h1000;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                apply(1'b1, 1'b0, d);
                d = d + 1'b1;
            end else begin
                apply(1'b0, 1'b1, '0);
            end
            n_cmp++;
            if ({bus.data_out_ref, bus.empty_ref} !== {m_dout, (i % 2 == 1)}) begin
                n_fail++;
                $display("FAIL wrap_c%0d: got %h/%b expected %h/%b", i, bus.data_out_ref,
                         bus.empty_ref, m_dout, (i % 2 == 1));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [W+4:0] got;
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, W'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        got = {bus.data_out_ref, bus.wr_ack_ref, bus.overflow_ref, bus.underflow_ref,
               bus.full_ref, bus.empty_ref};
        n_cmp++;
        if (got !== {16'h0000, 5'b00001}) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h expected %h", got, {16'h0000, 5'b00001});
        end
        bus.wr_en   = 1'b1;
        bus.data_in = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_cmp++;
        if ({bus.empty_ref, bus.wr_ack_ref} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_ignore: got %b expected 10", {bus.empty_ref, bus.wr_ack_ref});
        end
        rst_n = 1'b1;
        apply(1'b0, 1'b1, '0);
        n_cmp++;
        if ({bus.underflow_ref, bus.empty_ref, bus.data_out_ref} !== {2'b11, 16'h0000}) begin
            n_fail++;
            $display("FAIL postreset_underflow: got %h expected %h",
                     {bus.underflow_ref, bus.empty_ref, bus.data_out_ref}, {2'b11, 16'h0000});
        end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        logic [W+6:0] got;
        logic [W+6:0] exp;
        for (int i = 0; i < 400; i++) begin
            // Shift bias every 100 cycles so both full and empty regions are exercised.
            w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            apply(w, r, W'($urandom));
            got = {bus.data_out_ref, bus.wr_ack_ref, bus.overflow_ref, bus.underflow_ref, got_flags()};
            exp = {m_dout, m_ack, m_ovf, m_udf, exp_flags()};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_ref_model.md
# fifo_ref_model

Cycle-accurate golden model of the synchronous FIFO, instantiated in the testbench top beside the DUT on the same `FIFO_if` stimulus. It drives the `*_ref` signals that the negedge monitor copies into the scoreboard for comparison against DUT outputs. It is written as synthesizable-style RTL so that its behaviour is unambiguous and reviewable as the contract the DUT must meet.

## Interface
- FIFO_WIDTH, 16, data word width in bits
- FIFO_DEPTH, 8, number of storage entries (≥4, need not be a power of two)

- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out_ref  out  FIFO_WIDTH  registered read data
- wr_ack_ref  out  1  registered: previous-cycle write accepted
- overflow_ref  out  1  registered: previous-cycle write rejected (full)
- underflow_ref  out  1  registered: previous-cycle read rejected (empty)
- full_ref  out  1  combinational: count == FIFO_DEPTH
- almostfull_ref  out  1  combinational: count == FIFO_DEPTH-1
- empty_ref  out  1  combinational: count == 0
- almostempty_ref  out  1  combinational: count == 1

## Operation
- State: memory FIFO_DEPTH×FIFO_WIDTH, wr_ptr and rd_ptr of width $clog2(FIFO_DEPTH), count of width $clog2(FIFO_DEPTH)+1.
- Write accepted when wr_en && count < FIFO_DEPTH: mem[wr_ptr] ← data_in, wr_ptr advances, wr_ack_ref ← 1, overflow_ref ← 0.
- Write rejected when wr_en && full: no storage change, wr_ack_ref ← 0, overflow_ref ← 1.
- No write request: wr_ack_ref ← 0, overflow_ref ← 0.
- Read accepted when rd_en && count > 0: data_out_ref ← mem[rd_ptr], rd_ptr advances, underflow_ref ← 0.
- Read rejected when rd_en && empty: underflow_ref ← 1; data_out_ref holds.
- No read request: underflow_ref ← 0; data_out_ref holds.
- Count update: +1 write-only accepted, −1 read-only accepted, unchanged if both or neither accepted.
- Simultaneous wr_en && rd_en:
  - empty: write only; underflow_ref ← 1, count → 1.
  - full: read only; overflow_ref ← 1, count → FIFO_DEPTH-1.
  - otherwise: both accepted; count unchanged; read returns the old head, never the word being written.
- Pointer wrap: explicit compare, FIFO_DEPTH-1 → 0, so non-power-of-two depths are legal.
- Flag exclusivity: full/almostfull never both 1; empty/almostempty never both 1.
- Reset (rst_n low, any time, including mid-burst): pointers, count, data_out_ref, wr_ack_ref, overflow_ref and underflow_ref clear to 0 immediately, without waiting for a clock edge. Consequently empty_ref = 1 and full_ref = almostfull_ref = almostempty_ref = 0. Memory contents are not cleared and are never observable after reset.
- While rst_n is low, wr_en and rd_en are ignored.

## Timing
- Write latency: a word written at edge N is readable at edge N+1; data_out_ref shows it after edge N+1.
- Registered outputs change only on posedge clk or on assertion of rst_n.
- Combinational flags settle in the same cycle as the count change.
- All outputs are stable before negedge, which is where the monitor samples.
- First posedge after rst_n deasserts acts on inputs normally; no extra recovery cycle.

## Test plan
- Reset then idle 3 cycles -> empty_ref=1, full_ref=0, wr_ack_ref=0, overflow_ref=0, underflow_ref=0, data_out_ref=0.
- Write 0x0001..0x0008 on consecutive cycles, then a 9th write of 0xFFFF -> wr_ack_ref=1 for 8 cycles; almostfull_ref=1 after the 7th; full_ref=1 after the 8th; 9th gives overflow_ref=1, wr_ack_ref=0.
- From full, read 9 times -> data_out_ref = 0x0001..0x0008 in order; almostempty_ref=1 after the 7th; empty_ref=1 after the 8th; 9th gives underflow_ref=1, data_out_ref holds 0x0008.
- Simultaneous wr/rd: on empty, write 0x00AA -> count 1, underflow_ref=1. At count 4, read returns the old head and count stays 4. On full, read -> overflow_ref=1, count 7.
- Wrap: 20 cycles of alternating single write/read with incrementing data -> every read equals its matching write across the pointer wraparound; empty_ref toggles each cycle.
- Write 5 words, assert rst_n mid-cycle (between edges) -> outputs clear before the next posedge, empty_ref=1. After release, the next read gives underflow_ref=1.
